// File: rtl/cache_pkg.sv
// Shared cache read-path types and default geometry for the way-select and tag logic.
package cache_pkg;

  localparam int unsigned CACHE_LINE_BYTES = 64;
  localparam int unsigned CACHE_WAYS       = 4;
  localparam int unsigned CACHE_WORD_BYTES = 4;

  localparam int unsigned LINE_BITS = CACHE_LINE_BYTES * 8;
  localparam int unsigned WORD_BITS = CACHE_WORD_BYTES * 8;
  localparam int unsigned WAY_W     = $clog2(CACHE_WAYS);
  localparam int unsigned OFS_W     = $clog2(CACHE_LINE_BYTES / CACHE_WORD_BYTES);

  typedef logic [WAY_W-1:0] way_idx_t;

  typedef struct packed {
    logic [LINE_BITS-1:0] line;
    logic [WORD_BITS-1:0] word;
    way_idx_t             way;
    logic                 hit;
    logic                 multi_hit;
  } sel_result_t;

endpackage

// File: rtl/way_prio_enc.sv
// Lowest-index priority encoder over a tag-compare hit vector, with hit and multi-hit flags.
module way_prio_enc #(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WayW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0] i_sel,
  output logic [WayW-1:0] o_way,
  output logic            o_hit,
  output logic            o_multi_hit
);

  always_comb begin
    o_way = '0;
    // Scan downward so the lowest set bit is the last assignment and wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (i_sel[i]) o_way = WayW'(i);
    end
  end

  assign o_hit = |i_sel;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi_hit = |(i_sel & (i_sel - WAYS'(1)));

endmodule

// File: rtl/way_select_pipe.sv
// Registered way-select: priority-picks the hit way, extracts the addressed word and
// returns the result through a 2-entry valid/ready buffer; counts multi-hit requests.
module way_select_pipe
  import cache_pkg::*;
#(
  parameter int unsigned LINE_SIZE_BYTES = CACHE_LINE_BYTES,
  parameter int unsigned WAYS            = CACHE_WAYS,
  parameter int unsigned WORD_BYTES      = CACHE_WORD_BYTES,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned LineW = LINE_SIZE_BYTES * 8,
  localparam int unsigned WordW = WORD_BYTES * 8,
  localparam int unsigned WayW  = $clog2(WAYS),
  localparam int unsigned OfsW  = $clog2(LINE_SIZE_BYTES / WORD_BYTES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [LineW-1:0] i_data [WAYS],
  input  logic [WAYS-1:0]  i_sel,
  input  logic [OfsW-1:0]  i_word_ofs,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LineW-1:0] o_line,
  output logic [WordW-1:0] o_word,
  output logic [WayW-1:0]  o_way,
  output logic             o_hit,
  output logic             o_multi_hit,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_multi_hit_cnt
);

  // Same shape as sel_result_t, sized by this instance's parameters.
  typedef struct packed {
    logic [LineW-1:0] line;
    logic [WordW-1:0] word;
    logic [WayW-1:0]  way;
    logic             hit;
    logic             multi_hit;
  } entry_t;

  logic [WayW-1:0]  enc_way;
  logic             enc_hit;
  logic             enc_multi;
  logic [LineW-1:0] sel_line;
  entry_t           new_entry;

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  logic [CNT_W-1:0] cnt_q;

  way_prio_enc #(
    .WAYS(WAYS)
  ) u_prio_enc (
    .i_sel      (i_sel),
    .o_way      (enc_way),
    .o_hit      (enc_hit),
    .o_multi_hit(enc_multi)
  );

  assign sel_line = enc_hit ? i_data[enc_way] : '0;

  always_comb begin
    new_entry.line      = sel_line;
    new_entry.word      = sel_line[int'(i_word_ofs) * WordW +: WordW];
    new_entry.way       = enc_way;
    new_entry.hit       = enc_hit;
    new_entry.multi_hit = enc_multi;
  end

  assign o_ready = (count_q != 2'd2);
  assign o_valid = (count_q != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr_cnt) begin
      cnt_q <= '0;
    end else if (push && enc_multi && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_line          = mem_q[rd_ptr_q].line;
  assign o_word          = mem_q[rd_ptr_q].word;
  assign o_way           = mem_q[rd_ptr_q].way;
  assign o_hit           = mem_q[rd_ptr_q].hit;
  assign o_multi_hit     = mem_q[rd_ptr_q].multi_hit;
  assign o_multi_hit_cnt = cnt_q;

endmodule

// File: tb/tb_way_select_pipe.sv
// Directed bench for way_select_pipe: selection, miss/multi-hit flags, counter, buffering, reset.
module tb_way_select_pipe;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [511:0] i_data [4];
  logic [3:0]   i_sel;
  logic [3:0]   i_word_ofs;
  logic         o_valid;
  logic         i_ready;
  logic [511:0] o_line;
  logic [31:0]  o_word;
  logic [1:0]   o_way;
  logic         o_hit;
  logic         o_multi_hit;
  logic         i_clr_cnt;
  logic [15:0]  o_multi_hit_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  way_select_pipe dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_sel          (i_sel),
    .i_word_ofs     (i_word_ofs),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_line         (o_line),
    .o_word         (o_word),
    .o_way          (o_way),
    .o_hit          (o_hit),
    .o_multi_hit    (o_multi_hit),
    .i_clr_cnt      (i_clr_cnt),
    .o_multi_hit_cnt(o_multi_hit_cnt)
  );

  // Word w of way v holds {A5, v, w}, so every word in the array is unique.
  function automatic logic [511:0] mk_line(int way);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = {8'hA5, 8'(way), 16'(w)};
    return l;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr_cnt = 1'b0;
    i_sel = '0; i_word_ofs = '0;
    for (int w = 0; w < 4; w++) i_data[w] = mk_line(w);
    #3;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_ready); end
    n_cmp++; if (o_line !== '0) begin n_fail++; $display("FAIL reset_line got %h want 0", o_line); end
    n_cmp++; if ({o_word, o_way, o_hit, o_multi_hit} !== '0) begin
      n_fail++; $display("FAIL reset_fields got %h/%0d/%b/%b want 0", o_word, o_way, o_hit, o_multi_hit);
    end
    n_cmp++; if (o_multi_hit_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", o_multi_hit_cnt); end
    @(negedge i_clk) i_rst_n = 1'b1;
    step();
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_idle got v=%b r=%b want v=0 r=1", o_valid, o_ready);
    end
  endtask

  task automatic test_single_hit();
    i_valid = 1'b1; i_sel = 4'b0100; i_word_ofs = 4'd3;
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid got %b want 1", o_valid); end
    n_cmp++; if (o_way !== 2'd2) begin n_fail++; $display("FAIL hit_way got %0d want 2", o_way); end
    n_cmp++; if (o_hit !== 1'b1 || o_multi_hit !== 1'b0) begin
      n_fail++; $display("FAIL hit_flags got hit=%b multi=%b want 1/0", o_hit, o_multi_hit);
    end
    n_cmp++; if (o_word !== 32'hA502_0003) begin n_fail++; $display("FAIL hit_word got %h want a5020003", o_word); end
    n_cmp++; if (o_line !== mk_line(2)) begin n_fail++; $display("FAIL hit_line got %h want %h", o_line, mk_line(2)); end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hit_drained got %b want 0", o_valid); end
  endtask

  task automatic test_miss();
    i_valid = 1'b1; i_sel = 4'b0000; i_word_ofs = 4'd5;
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || o_hit !== 1'b0) begin
      n_fail++; $display("FAIL miss_flags got v=%b hit=%b want 1/0", o_valid, o_hit);
    end
    n_cmp++; if (o_line !== '0 || o_word !== 32'h0 || o_way !== 2'd0) begin
      n_fail++; $display("FAIL miss_data got way=%0d word=%h want 0/0 line 0", o_way, o_word);
    end
    n_cmp++; if (o_multi_hit !== 1'b0 || o_multi_hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL miss_cnt got multi=%b cnt=%0d want 0/0", o_multi_hit, o_multi_hit_cnt);
    end
    step();
  endtask

  task automatic test_multi_hit();
    i_valid = 1'b1; i_sel = 4'b1010; i_word_ofs = 4'd1;
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_way !== 2'd1 || o_multi_hit !== 1'b1 || o_hit !== 1'b1) begin
      n_fail++; $display("FAIL multi_flags got way=%0d multi=%b hit=%b want 1/1/1", o_way, o_multi_hit, o_hit);
    end
    n_cmp++; if (o_word !== 32'hA501_0001) begin n_fail++; $display("FAIL multi_word got %h want a5010001", o_word); end
    n_cmp++; if (o_multi_hit_cnt !== 16'd1) begin n_fail++; $display("FAIL multi_cnt got %0d want 1", o_multi_hit_cnt); end
    // Clear must beat an increment arriving in the same cycle.
    i_valid = 1'b1; i_sel = 4'b0110; i_clr_cnt = 1'b1;
    step();
    i_valid = 1'b0; i_clr_cnt = 1'b0;
    n_cmp++; if (o_multi_hit_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_priority got %0d want 0", o_multi_hit_cnt); end
    n_cmp++; if (o_way !== 2'd1 || o_multi_hit !== 1'b1) begin
      n_fail++; $display("FAIL multi2_flags got way=%0d multi=%b want 1/1", o_way, o_multi_hit);
    end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL multi_drained got %b want 0", o_valid); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    i_valid = 1'b1; i_sel = 4'b0001; i_word_ofs = 4'd2;
    step();
    n_cmp++; if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_word !== 32'hA500_0002) begin
      n_fail++; $display("FAIL bp_first got v=%b r=%b word=%h want 1/1/a5000002", o_valid, o_ready, o_word);
    end
    i_sel = 4'b0010; i_word_ofs = 4'd4;
    step();
    n_cmp++; if (o_ready !== 1'b0 || o_word !== 32'hA500_0002) begin
      n_fail++; $display("FAIL bp_full got r=%b word=%h want 0/a5000002", o_ready, o_word);
    end
    i_sel = 4'b1000; i_word_ofs = 4'd7;
    step();
    step();
    n_cmp++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_word !== 32'hA500_0002 || o_way !== 2'd0) begin
      n_fail++; $display("FAIL bp_stall got r=%b v=%b word=%h way=%0d want 0/1/a5000002/0",
                         o_ready, o_valid, o_word, o_way);
    end
    n_cmp++; if (o_line !== mk_line(0)) begin n_fail++; $display("FAIL bp_stall_line got %h want %h", o_line, mk_line(0)); end
    i_ready = 1'b1;
    step();
    n_cmp++; if (o_word !== 32'hA501_0004 || o_way !== 2'd1 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain2 got word=%h way=%0d r=%b want a5010004/1/1", o_word, o_way, o_ready);
    end
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || o_word !== 32'hA503_0007 || o_way !== 2'd3) begin
      n_fail++; $display("FAIL bp_drain3 got v=%b word=%h way=%0d want 1/a5030007/3", o_valid, o_word, o_way);
    end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", o_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_word;
    i_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      i_valid = 1'b1; i_sel = 4'(1 << (k % 4)); i_word_ofs = 4'(k % 16);
      exp_word = {8'hA5, 8'(k % 4), 16'(k % 16)};
      n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", k, o_ready); end
      step();
      n_cmp++; if (o_valid !== 1'b1 || o_word !== exp_word || o_way !== 2'(k % 4)) begin
        n_fail++; $display("FAIL stream[%0d] got v=%b word=%h way=%0d want 1/%h/%0d",
                           k, o_valid, o_word, o_way, exp_word, k % 4);
      end
    end
    i_valid = 1'b0;
    step();
    n_cmp++; if (o_valid !== 1'b0 || o_multi_hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stream_end got v=%b cnt=%0d want 0/0", o_valid, o_multi_hit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0; i_valid = 1'b1; i_sel = 4'b0011; i_word_ofs = 4'd0;
    step();
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_multi_hit_cnt !== 16'd2) begin
      n_fail++; $display("FAIL rst_mid_pre got r=%b v=%b cnt=%0d want 0/1/2", o_ready, o_valid, o_multi_hit_cnt);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_multi_hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_async got v=%b r=%b cnt=%0d want 0/1/0", o_valid, o_ready, o_multi_hit_cnt);
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    i_ready = 1'b1;
    step();
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_after got v=%b r=%b want 0/1", o_valid, o_ready);
    end
    i_valid = 1'b1; i_sel = 4'b1000; i_word_ofs = 4'd15;
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || o_word !== 32'hA503_000F) begin
      n_fail++; $display("FAIL rst_mid_resume got v=%b word=%h want 1/a503000f", o_valid, o_word);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss();
    test_multi_hit();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/way_select_pipe.md
Name: way_select_pipe

Overview:
- Registered, parametrised successor to the combinational one-hot way-select mux in the set-associative cache read path.
- Accepts the per-way line data plus a hit vector from tag compare. Priority-selects the hit way and extracts the addressed word.
- Flags miss and multi-hit, and delivers the result through a 2-entry valid/ready output buffer to the load/refill return path.
- Keeps a saturating multi-hit error counter for debug.

Parameters:
- LINE_SIZE_BYTES, 64, bytes per cache line; LINE_BITS = LINE_SIZE_BYTES*8.
- WAYS, 4, associativity, >=2; WAY_W = $clog2(WAYS).
- WORD_BYTES, 4, bytes per returned word; must divide LINE_SIZE_BYTES; OFS_W = $clog2(LINE_SIZE_BYTES/WORD_BYTES).
- CNT_W, 16, width of the multi-hit error counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request this cycle.
- i_data  in  [LINE_BITS-1:0] x WAYS (unpacked array)  line data per way.
- i_sel  in  WAYS  hit vector from tag compare; may be zero or have several bits set.
- i_word_ofs  in  OFS_W  word index within the line.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_line  out  LINE_BITS  selected line.
- o_word  out  WORD_BYTES*8  selected word.
- o_way  out  WAY_W  index of the selected way.
- o_hit  out  1  at least one i_sel bit was set.
- o_multi_hit  out  1  more than one i_sel bit was set.
- i_clr_cnt  in  1  synchronous clear of the error counter.
- o_multi_hit_cnt  out  CNT_W  saturating count of accepted multi-hit requests.

Behaviour:
- Reset (async assert, sync deassert handled upstream): buffer empty; o_valid=0; o_ready=1; o_line, o_word, o_way, o_hit, o_multi_hit, o_multi_hit_cnt all 0.
- Accept: a transfer occurs when i_valid && o_ready. o_ready = (buffer count < 2), driven from registered count only; it has no combinational path from i_ready.
- Selection, combinational on the accepted inputs:
  - way = index of the lowest set bit of i_sel.
  - hit = |i_sel.
  - multi_hit = popcount(i_sel) > 1.
  - Miss (i_sel==0): way=0, line=0, word=0, hit=0.
  - Word = line[i_word_ofs*WORD_BITS +: WORD_BITS].
- Latency: a request accepted at rising edge N is presented with o_valid=1 after edge N. This is 1 cycle when the buffer is empty.
- Buffer: 2-entry FIFO of {line, word, way, hit, multi_hit}. Outputs come from the head entry.
  - Pop on o_valid && i_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - With i_ready held high and i_valid every cycle, throughput is 1 per cycle and count stays at 1.
  - Full (count==2): o_ready=0 and i_valid is ignored.
  - Empty: o_valid=0 and the data outputs hold their last popped value (do not care).
- Stall stability: while o_valid && !i_ready, all result outputs hold stable.
- Counter: increments on each accepted request with multi_hit=1 and saturates at 2^CNT_W-1. i_clr_cnt has priority over an increment in the same cycle and sets the counter to 0.
- Reset mid-operation: buffered entries are discarded, o_valid drops immediately, and the counter clears.

Decomposition:
- Shared package cache_pkg holds:
  - constants LINE_BITS, WORD_BITS, WAY_W, OFS_W;
  - typedef way_idx_t;
  - typedef sel_result_t, a struct {line, word, way, hit, multi_hit} used as the FIFO entry.
- One sub-module, way_prio_enc: combinational. Input is the hit vector; outputs are way index, hit and multi_hit. It is reusable by the replacement and tag logic.
- The FIFO is written inline as two entries with read/write pointers.

Test Plan:
- Single hit: i_sel=4'b0100, i_data[2]=pattern A, i_word_ofs=3, i_ready=1 -> next cycle o_valid=1, o_way=2, o_hit=1, o_multi_hit=0, o_word=A[127:96].
- Miss: i_sel=0 -> o_hit=0, o_line=0, o_word=0, o_way=0, counter unchanged.
- Multi-hit: i_sel=4'b1010 -> o_way=1, o_multi_hit=1, counter 0->1. Then i_clr_cnt and a multi-hit in the same cycle -> counter=0.
- Backpressure: i_ready=0 with 3 back-to-back requests -> o_ready falls after the 2nd is accepted and the 3rd is held. Outputs stay stable on the 1st result. Raising i_ready drains the results in order 1, 2, 3.
- Streaming: 100 requests with i_valid and i_ready held at 1 -> one result per cycle, 1-cycle latency, o_ready constantly 1.
- Reset mid-stream: assert i_rst_n=0 while 2 entries are buffered -> o_valid=0 asynchronously, count=0, o_multi_hit_cnt=0. After release, o_ready=1.
